// File: rtl/cart_image_loader.sv
// Cartridge download qualifier: forwards HPS ioctl bytes into cart RAM, decodes and
// strips the A78 header, and publishes cart size/flags with a completion pulse.
module cart_image_loader #(
  parameter int ADDR_W  = 18,
  parameter int HDR_LEN = 128
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              cart_is_7800,
  output logic [31:0]       cart_size,
  output logic [15:0]       cart_flags,
  output logic [7:0]        joy0_type,
  output logic [7:0]        joy1_type,
  output logic [7:0]        cart_region,
  output logic [7:0]        cart_save,
  output logic              busy,
  output logic              load_done,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

  localparam logic [39:0] MAGIC = "ATARI";
  localparam logic [24:0] HDR   = 25'(HDR_LEN);

  state_t      state, state_nxt;
  logic        cart_dl, load_entry, accept;
  logic [39:0] magic, magic_nxt;
  logic        match_now, is_7800_eff;
  logic [24:0] wr_addr, last_addr;
  logic        addr_over, wrote;
  logic [31:0] last_p1, size_calc;

  assign cart_dl    = ioctl_download && (ioctl_index != 8'd0);
  assign load_entry = (state == IDLE) && cart_dl;
  assign accept     = (state == LOAD) && cart_dl && ioctl_wr;
  assign busy       = (state != IDLE);

  // Header magic is shifted in over offsets 1..5; offset 5 may complete it this cycle.
  assign magic_nxt   = {magic[31:0], ioctl_dout};
  assign match_now   = accept && (ioctl_addr == 25'd5) && (magic_nxt == MAGIC);
  assign is_7800_eff = cart_is_7800 || match_now;

  assign wr_addr   = (is_7800_eff && (ioctl_addr >= HDR)) ? (ioctl_addr - HDR) : ioctl_addr;
  assign addr_over = ((wr_addr >> ADDR_W) != 25'd0);

  assign last_p1 = {7'd0, last_addr} + 32'd1;

  always_comb begin
    size_calc = 32'd0;
    if (wrote) begin
      if (!cart_is_7800)
        size_calc = last_p1;
      else if (last_addr >= HDR)
        size_calc = last_p1 - 32'(HDR_LEN);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cart_dl)  state_nxt = LOAD;
      LOAD:    if (!cart_dl) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ram_addr     <= '0;
      ram_data     <= 8'd0;
      ram_we       <= 1'b0;
      cart_is_7800 <= 1'b0;
      cart_size    <= 32'd0;
      cart_flags   <= 16'd0;
      joy0_type    <= 8'd0;
      joy1_type    <= 8'd0;
      cart_region  <= 8'd0;
      cart_save    <= 8'd0;
      load_done    <= 1'b0;
      overflow     <= 1'b0;
      magic        <= 40'd0;
      last_addr    <= 25'd0;
      wrote        <= 1'b0;
    end else begin
      ram_we    <= 1'b0;
      load_done <= 1'b0;

      if (load_entry) begin
        overflow     <= 1'b0;
        magic        <= 40'd0;
        cart_is_7800 <= 1'b0;
        cart_flags   <= 16'd0;
        joy0_type    <= 8'd0;
        joy1_type    <= 8'd0;
        cart_region  <= 8'd0;
        cart_save    <= 8'd0;
        wrote        <= 1'b0;
      end

      if (accept) begin
        last_addr <= ioctl_addr;
        wrote     <= 1'b1;
        if ((ioctl_addr >= 25'd1) && (ioctl_addr <= 25'd5)) magic <= magic_nxt;
        if (match_now) cart_is_7800 <= 1'b1;
        case (ioctl_addr)
          25'd53:  cart_flags[15:8] <= ioctl_dout;
          25'd54:  cart_flags[7:0]  <= ioctl_dout;
          25'd55:  joy0_type        <= ioctl_dout;
          25'd56:  joy1_type        <= ioctl_dout;
          25'd57:  cart_region      <= ioctl_dout;
          25'd58:  cart_save        <= ioctl_dout;
          default: ;
        endcase
        // Bytes past RAM capacity are dropped but still count towards the size.
        if (addr_over) begin
          overflow <= 1'b1;
        end else begin
          ram_we   <= 1'b1;
          ram_addr <= wr_addr[ADDR_W-1:0];
          ram_data <= ioctl_dout;
        end
      end

      if (state == FINISH) begin
        cart_size <= size_calc;
        load_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cart_image_loader.sv
// Directed bench for cart_image_loader: RAM writes scored against an expected queue,
// header fields, size and completion pulse checked after each download.
module tb_cart_image_loader;

  localparam int ADDR_W  = 18;
  localparam int HDR_LEN = 128;
  localparam int CAP     = 1 << ADDR_W;
  localparam int W       = ADDR_W + 8;

  logic              clk_sys;
  logic              reset;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_we;
  logic              cart_is_7800;
  logic [31:0]       cart_size;
  logic [15:0]       cart_flags;
  logic [7:0]        joy0_type, joy1_type, cart_region, cart_save;
  logic              busy, load_done, overflow;

  cart_image_loader #(.ADDR_W(ADDR_W), .HDR_LEN(HDR_LEN)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .cart_is_7800(cart_is_7800), .cart_size(cart_size), .cart_flags(cart_flags),
    .joy0_type(joy0_type), .joy1_type(joy1_type),
    .cart_region(cart_region), .cart_save(cart_save),
    .busy(busy), .load_done(load_done), .overflow(overflow)
  );

  // Clock / reset
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_head;
  int         act_we   = 0;
  int         exp_we   = 0;
  int         done_cnt = 0;
  bit         busy_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every RAM write must match the head of the expected queue.
  always @(negedge clk_sys) begin
    if (load_done) done_cnt++;
    if (busy) busy_seen = 1;
    if (ram_we) begin
      act_we++;
      if (exp_q.size() == 0) begin
        check("ram_we_unexpected", 32'd1, 32'd0);
      end else begin
        exp_head = exp_q.pop_front();
        check("ram_write", 32'({ram_addr, ram_data}), 32'(exp_head));
      end
    end
  end

  // mode: 0 = raw 2600 image, 1 = A78 image, 2 = BIOS
  function automatic logic [7:0] byte_for(input int off, input int mode);
    if (mode == 1 && off < HDR_LEN) begin
      case (off)
        0:  return 8'h01;
        1:  return 8'h41;
        2:  return 8'h54;
        3:  return 8'h41;
        4:  return 8'h52;
        5:  return 8'h49;
        53: return 8'h12;
        54: return 8'h34;
        55: return 8'h01;
        56: return 8'h02;
        57: return 8'h01;
        58: return 8'h02;
        default: return 8'h00;
      endcase
    end
    if (off == 1) return 8'h00;
    return 8'(off ^ (off >> 8) ^ 8'h5a);
  endfunction

  // Driver tasks
  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    ioctl_wr       = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int mode);
    int a;
    for (int off = lo; off <= hi; off++) begin
      @(negedge clk_sys);
      if (mode == 1 && off == 201) begin
        check("lat_we_off200", 32'(ram_we), 32'd1);
        check("lat_addr_off200", 32'(ram_addr), 32'd72);
      end
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(off);
      ioctl_dout = byte_for(off, mode);
      if (mode != 2) begin
        a = (mode == 1 && off >= HDR_LEN) ? off - HDR_LEN : off;
        if (a < CAP) begin
          exp_q.push_back({ADDR_W'(a), byte_for(off, mode)});
          exp_we++;
        end
      end
    end
  endtask

  task automatic end_dl();
    @(negedge clk_sys);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    repeat (6) @(negedge clk_sys);
  endtask

  task automatic verify_load(input int done0, input logic is78, input logic [31:0] size,
                             input logic [15:0] flags, input logic [7:0] j0, input logic [7:0] j1,
                             input logic [7:0] rg, input logic [7:0] sv, input logic ovf);
    check("load_done_pulses", 32'(done_cnt - done0), 32'd1);
    check("cart_is_7800", 32'(cart_is_7800), 32'(is78));
    check("cart_size", cart_size, size);
    check("cart_flags", 32'(cart_flags), 32'(flags));
    check("joy0_type", 32'(joy0_type), 32'(j0));
    check("joy1_type", 32'(joy1_type), 32'(j1));
    check("cart_region", 32'(cart_region), 32'(rg));
    check("cart_save", 32'(cart_save), 32'(sv));
    check("overflow", 32'(overflow), 32'(ovf));
    check("busy_idle", 32'(busy), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("write_count", 32'(act_we), 32'(exp_we));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_is_7800"}, 32'(cart_is_7800), 32'd0);
    check({tag, "_size"}, cart_size, 32'd0);
    check({tag, "_flags"}, 32'(cart_flags), 32'd0);
    check({tag, "_joys"}, 32'({joy0_type, joy1_type}), 32'd0);
    check({tag, "_region_save"}, 32'({cart_region, cart_save}), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_data"}, 32'(ram_data), 32'd0);
  endtask

  int done0;

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'd0;
    repeat (3) @(negedge clk_sys);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    // A78 image, 49152 payload bytes, contiguous
    done0 = done_cnt;
    start_dl(8'd1);
    send_range(0, HDR_LEN + 49152 - 1, 1);
    end_dl();
    verify_load(done0, 1'b1, 32'd49152, 16'h1234, 8'd1, 8'd2, 8'd1, 8'd2, 1'b0);

    // Raw 2600 image; header fields still latch whatever sits at 53..58
    done0 = done_cnt;
    start_dl(8'd2);
    send_range(0, 4095, 0);
    end_dl();
    verify_load(done0, 1'b0, 32'd4096, {byte_for(53, 0), byte_for(54, 0)},
                byte_for(55, 0), byte_for(56, 0), byte_for(57, 0), byte_for(58, 0), 1'b0);

    // A78 image running 16 bytes past RAM capacity (sparse offsets)
    done0 = done_cnt;
    start_dl(8'd1);
    send_range(0, 200, 1);
    send_range(HDR_LEN + CAP + 16 - 48, HDR_LEN + CAP + 16 - 1, 1);
    end_dl();
    verify_load(done0, 1'b1, 32'd262160, 16'h1234, 8'd1, 8'd2, 8'd1, 8'd2, 1'b1);

    // Overflow stays sticky in IDLE and clears on the next load entry; then reset mid-load
    start_dl(8'd1);
    check("ovf_sticky_idle", 32'(overflow), 32'd1);
    @(negedge clk_sys);
    check("ovf_cleared_entry", 32'(overflow), 32'd0);
    send_range(0, 999, 1);
    @(negedge clk_sys);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    reset          = 1'b1;
    done0          = done_cnt;
    @(negedge clk_sys);
    check_all_zero("midreset");
    reset = 1'b0;
    repeat (5) @(negedge clk_sys);
    check("midreset_no_done", 32'(done_cnt - done0), 32'd0);
    check("midreset_q_drained", 32'(exp_q.size()), 32'd0);

    // Full A78 reload after the reset (head and tail of payload)
    done0 = done_cnt;
    start_dl(8'd1);
    send_range(0, 639, 1);
    send_range(HDR_LEN + 49152 - 256, HDR_LEN + 49152 - 1, 1);
    end_dl();
    verify_load(done0, 1'b1, 32'd49152, 16'h1234, 8'd1, 8'd2, 8'd1, 8'd2, 1'b0);

    // BIOS download is invisible to this block
    busy_seen = 0;
    done0     = done_cnt;
    start_dl(8'd0);
    send_range(0, 4095, 2);
    end_dl();
    check("bios_busy", 32'(busy_seen), 32'd0);
    check("bios_no_done", 32'(done_cnt - done0), 32'd0);
    check("bios_size_kept", cart_size, 32'd49152);
    check("bios_write_count", 32'(act_we), 32'(exp_we));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
